// File: rtl/f1_light_seq.sv
// F1 start-light sequencer: thermometer fill paced by en, hold/delay handshake, lights out.
// Optional abort input is enabled by defining F1_SEQ_ABORT_EN.
module f1_light_seq #(
  parameter int unsigned N_LIGHTS   = 8,
  parameter int unsigned STEP_TICKS = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                trigger,
  input  logic                delay_done,
`ifdef F1_SEQ_ABORT_EN
  input  logic                abort,
`endif
  output logic                cmd_seq,
  output logic                cmd_delay,
  output logic [N_LIGHTS-1:0] data_out
);

  localparam int unsigned LCW = $clog2(N_LIGHTS + 1);
  localparam int unsigned TCW = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HOLD = 2'd2,
    WAIT = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [LCW-1:0]        light_cnt_q, light_cnt_d;
  logic [TCW-1:0]        tick_cnt_q, tick_cnt_d;
  logic                  trig_q;
  logic                  trig_edge_c;
  logic                  cmd_seq_d, cmd_delay_d;
  logic [N_LIGHTS-1:0]   data_d;

  assign trig_edge_c = trigger & ~trig_q;

  // Next-state, counter and output decode; outputs derive from the next register values.
  always_comb begin
    state_d     = state_q;
    light_cnt_d = light_cnt_q;
    tick_cnt_d  = tick_cnt_q;
    cmd_seq_d   = 1'b0;
    cmd_delay_d = 1'b0;
    data_d      = '0;

    case (state_q)
      IDLE: begin
        if (trig_edge_c) begin
          state_d     = FILL;
          light_cnt_d = '0;
          tick_cnt_d  = '0;
        end
      end
      FILL: begin
        if (en) begin
          if (tick_cnt_q == TCW'(STEP_TICKS - 1)) begin
            tick_cnt_d  = '0;
            light_cnt_d = light_cnt_q + LCW'(1);
            if (light_cnt_q == LCW'(N_LIGHTS - 1)) begin
              state_d = HOLD;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TCW'(1);
          end
        end
      end
      HOLD: state_d = WAIT;
      WAIT: begin
        if (delay_done) begin
          state_d     = IDLE;
          light_cnt_d = '0;
          tick_cnt_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef F1_SEQ_ABORT_EN
    // Abort overrides en and delay_done in any active state.
    if (abort && (state_q != IDLE)) begin
      state_d     = IDLE;
      light_cnt_d = '0;
      tick_cnt_d  = '0;
    end
`endif

    cmd_seq_d   = (state_d == FILL);
    cmd_delay_d = (state_d == HOLD);
    for (int unsigned i = 0; i < N_LIGHTS; i++) begin
      data_d[i] = (32'(light_cnt_d) > i);
    end
    if (state_d == HOLD || state_d == WAIT) begin
      data_d = '1;
    end else if (state_d == IDLE) begin
      data_d = '0;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      light_cnt_q <= '0;
      tick_cnt_q  <= '0;
      trig_q      <= 1'b0;
      cmd_seq     <= 1'b0;
      cmd_delay   <= 1'b0;
      data_out    <= '0;
    end else begin
      state_q     <= state_d;
      light_cnt_q <= light_cnt_d;
      tick_cnt_q  <= tick_cnt_d;
      trig_q      <= trigger;
      cmd_seq     <= cmd_seq_d;
      cmd_delay   <= cmd_delay_d;
      data_out    <= data_d;
    end
  end

endmodule

// File: tb/tb_f1_light_seq.sv
// Directed bench for f1_light_seq: 8 lights / 2 ticks per step, plus a 1-light / 1-tick instance.
module tb_f1_light_seq;

  logic       clk;
  logic       rst_n;
  logic       en, trigger, delay_done, abort;
  logic       cmd_seq, cmd_delay;
  logic [7:0] data_out;

  logic       en1, trig1, dd1, abort1;
  logic       cmd_seq1, cmd_delay1;
  logic [0:0] data1;

  int total = 0;
  int bad   = 0;

  f1_light_seq #(.N_LIGHTS(8), .STEP_TICKS(2)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .trigger    (trigger),
    .delay_done (delay_done),
`ifdef F1_SEQ_ABORT_EN
    .abort      (abort),
`endif
    .cmd_seq    (cmd_seq),
    .cmd_delay  (cmd_delay),
    .data_out   (data_out)
  );

  f1_light_seq #(.N_LIGHTS(1), .STEP_TICKS(1)) u_one (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en1),
    .trigger    (trig1),
    .delay_done (dd1),
`ifdef F1_SEQ_ABORT_EN
    .abort      (abort1),
`endif
    .cmd_seq    (cmd_seq1),
    .cmd_delay  (cmd_delay1),
    .data_out   (data1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse();
    en = 1'b1;
    tick();
    en = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    total++; if (data_out !== 8'h00) begin bad++; $display("FAIL reset_data got=%h want=00", data_out); end
    total++; if (cmd_seq !== 1'b0) begin bad++; $display("FAIL reset_seq got=%b want=0", cmd_seq); end
    total++; if (cmd_delay !== 1'b0) begin bad++; $display("FAIL reset_delay got=%b want=0", cmd_delay); end
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      en = ~en;
      tick();
      total++; if (data_out !== 8'h00 || cmd_seq !== 1'b0 || cmd_delay !== 1'b0) begin
        bad++; $display("FAIL idle_outputs c=%0d got=%h/%b/%b want=00/0/0", c, data_out, cmd_seq, cmd_delay);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_fill();
    logic [8:0] tmp;
    logic [7:0] exp;
    trigger = 1'b1;
    tick();
    total++; if (cmd_seq !== 1'b1 || data_out !== 8'h00) begin
      bad++; $display("FAIL fill_start got seq=%b data=%h want seq=1 data=00", cmd_seq, data_out);
    end
    for (int p = 1; p <= 16; p++) begin
      pulse();
      tmp = (9'd1 << (p / 2)) - 9'd1;
      exp = tmp[7:0];
      total++; if (data_out !== exp) begin bad++; $display("FAIL fill_data p=%0d got=%h want=%h", p, data_out, exp); end
      if (p < 16) begin
        total++; if (cmd_seq !== 1'b1 || cmd_delay !== 1'b0) begin
          bad++; $display("FAIL fill_ctrl p=%0d got seq=%b dly=%b want 1/0", p, cmd_seq, cmd_delay);
        end
        tick();
        total++; if (data_out !== exp) begin bad++; $display("FAIL fill_hold p=%0d got=%h want=%h", p, data_out, exp); end
      end else begin
        total++; if (cmd_seq !== 1'b0 || cmd_delay !== 1'b1) begin
          bad++; $display("FAIL hold_ctrl got seq=%b dly=%b want 0/1", cmd_seq, cmd_delay);
        end
      end
    end
    tick();
    total++; if (cmd_delay !== 1'b0 || data_out !== 8'hFF || cmd_seq !== 1'b0) begin
      bad++; $display("FAIL wait_entry got dly=%b data=%h seq=%b want 0/FF/0", cmd_delay, data_out, cmd_seq);
    end
  endtask

  task automatic test_wrap();
    for (int c = 0; c < 3; c++) begin
      tick();
      total++; if (data_out !== 8'hFF) begin bad++; $display("FAIL wait_hold c=%0d got=%h want=FF", c, data_out); end
    end
    delay_done = 1'b1;
    tick();
    delay_done = 1'b0;
    total++; if (data_out !== 8'h00) begin bad++; $display("FAIL lights_out got=%h want=00", data_out); end
    for (int c = 0; c < 3; c++) begin
      tick();
      total++; if (cmd_seq !== 1'b0) begin bad++; $display("FAIL held_trigger c=%0d got seq=%b want=0", c, cmd_seq); end
    end
    trigger = 1'b0;
    tick();
    trigger = 1'b1;
    tick();
    total++; if (cmd_seq !== 1'b1) begin bad++; $display("FAIL retrigger got seq=%b want=1", cmd_seq); end
  endtask

  task automatic test_ignore();
    delay_done = 1'b1;
    for (int p = 1; p <= 5; p++) pulse();
    total++; if (data_out !== 8'h03) begin bad++; $display("FAIL dd_ignored got=%h want=03", data_out); end
    trigger = 1'b0;
    tick();
    trigger = 1'b1;
    tick();
    total++; if (data_out !== 8'h03 || cmd_seq !== 1'b1) begin
      bad++; $display("FAIL edge_in_fill got data=%h seq=%b want 03/1", data_out, cmd_seq);
    end
    pulse();
    total++; if (data_out !== 8'h07) begin bad++; $display("FAIL tick_kept got=%h want=07", data_out); end
    for (int p = 7; p <= 16; p++) pulse();
    total++; if (data_out !== 8'hFF || cmd_delay !== 1'b1) begin
      bad++; $display("FAIL ignore_hold got data=%h dly=%b want FF/1", data_out, cmd_delay);
    end
    tick();
    total++; if (data_out !== 8'hFF || cmd_delay !== 1'b0) begin
      bad++; $display("FAIL dd_in_hold got data=%h dly=%b want FF/0", data_out, cmd_delay);
    end
    tick();
    total++; if (data_out !== 8'h00) begin bad++; $display("FAIL dd_in_wait got=%h want=00", data_out); end
    delay_done = 1'b0;
  endtask

  task automatic test_reset_mid();
    trigger = 1'b0;
    tick();
    trigger = 1'b1;
    tick();
    for (int p = 1; p <= 8; p++) pulse();
    total++; if (data_out !== 8'h0F) begin bad++; $display("FAIL pre_reset got=%h want=0F", data_out); end
    #2;
    rst_n   = 1'b0;
    trigger = 1'b0;
    #1;
    total++; if (data_out !== 8'h00 || cmd_seq !== 1'b0 || cmd_delay !== 1'b0) begin
      bad++; $display("FAIL async_reset got=%h/%b/%b want 00/0/0", data_out, cmd_seq, cmd_delay);
    end
    tick(); tick();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      en = ~en;
      tick();
      total++; if (data_out !== 8'h00 || cmd_seq !== 1'b0) begin
        bad++; $display("FAIL post_reset c=%0d got=%h/%b want 00/0", c, data_out, cmd_seq);
      end
    end
    en = 1'b0;
  endtask

`ifdef F1_SEQ_ABORT_EN
  task automatic test_abort();
    trigger = 1'b1;
    tick();
    for (int p = 1; p <= 6; p++) pulse();
    total++; if (data_out !== 8'h07) begin bad++; $display("FAIL pre_abort got=%h want=07", data_out); end
    abort = 1'b1;
    en    = 1'b1;
    tick();
    abort = 1'b0;
    en    = 1'b0;
    total++; if (data_out !== 8'h00 || cmd_seq !== 1'b0) begin
      bad++; $display("FAIL abort_fill got=%h/%b want 00/0", data_out, cmd_seq);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    total++; if (data_out !== 8'h00 || cmd_seq !== 1'b0 || cmd_delay !== 1'b0) begin
      bad++; $display("FAIL abort_idle got=%h/%b/%b want 00/0/0", data_out, cmd_seq, cmd_delay);
    end
    trigger = 1'b0;
    tick();
  endtask
`endif

  task automatic test_single();
    trig1 = 1'b1;
    tick();
    total++; if (cmd_seq1 !== 1'b1 || data1 !== 1'b0) begin
      bad++; $display("FAIL one_start got seq=%b data=%b want 1/0", cmd_seq1, data1);
    end
    en1 = 1'b1;
    tick();
    en1 = 1'b0;
    total++; if (data1 !== 1'b1 || cmd_delay1 !== 1'b1 || cmd_seq1 !== 1'b0) begin
      bad++; $display("FAIL one_hold got data=%b dly=%b seq=%b want 1/1/0", data1, cmd_delay1, cmd_seq1);
    end
    tick();
    total++; if (data1 !== 1'b1 || cmd_delay1 !== 1'b0) begin
      bad++; $display("FAIL one_wait got data=%b dly=%b want 1/0", data1, cmd_delay1);
    end
    dd1 = 1'b1;
    tick();
    dd1 = 1'b0;
    total++; if (data1 !== 1'b0) begin bad++; $display("FAIL one_out got=%b want=0", data1); end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; trigger = 1'b0; delay_done = 1'b0; abort = 1'b0;
    en1 = 1'b0; trig1 = 1'b0; dd1 = 1'b0; abort1 = 1'b0;
    test_reset();
    test_fill();
    test_wrap();
    test_ignore();
    test_reset_mid();
`ifdef F1_SEQ_ABORT_EN
    test_abort();
`endif
    test_single();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
